// File: rtl/code_lock.sv
// code_lock: parametrised sequential combination lock.
//
// One digit is accepted per cycle in which new_digit is high. Each digit is
// compared against position idx of a programmable code; a full correct
// sequence opens the lock, MAX_FAIL wrong digits lock it out for a while.
// While open the code can be replaced, and the lock relocks on any strobe
// or, optionally, after OPEN_CYCLES clocks.
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous, active-high, overrides every other input
//   value       in   [DIGIT_W]           digit, sampled when new_digit=1
//   new_digit   in   one-cycle strobe, one digit per high cycle
//                    (the keypad "new" strobe; "new" is a reserved word)
//   code_in     in   [CODE_LEN*DIGIT_W]  replacement code, digit 0 in LSBs
//   code_load   in   load code_in, honoured only while open
//   opened      out  high while open
//   locked_out  out  high while locked out
//   progress    out  correct digits entered so far
//   fail_count  out  wrong digits since last success or lockout
//   dbg_state   out  current FSM state (0 entry, 1 open, 2 lockout)
//
// Handshake: new_digit is a plain strobe with no back-pressure; every cycle
// it is high one digit is consumed, including back-to-back cycles. In
// lockout the strobe is consumed and discarded.
module code_lock #(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 3,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {4'd3, 4'd2, 4'd1},
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int OPEN_CYCLES    = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [DIGIT_W-1:0]                value,
  input  logic                              new_digit,
  input  logic [CODE_LEN*DIGIT_W-1:0]       code_in,
  input  logic                              code_load,
  output logic                              opened,
  output logic                              locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0]     progress,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count,
  output logic [1:0]                        dbg_state
);

  localparam int IDX_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [CODE_LEN*DIGIT_W-1:0]    code_q, code_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [FAIL_W-1:0]              fail_q, fail_d;
  logic [TMR_W-1:0]               tmr_q, tmr_d;
  logic [DIGIT_W-1:0]             cur_digit;

  // Expected digit at the current position.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = code_q[i*DIGIT_W +: DIGIT_W];
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_ENTRY: begin
        if (new_digit) begin
          // An X/Z digit makes the equality unknown, which takes the
          // mismatch branch.
          if (value == cur_digit) begin
            if (idx_q == IDX_W'(CODE_LEN - 1)) begin
              state_d = ST_OPEN;
              idx_d   = '0;
              fail_d  = '0;
              tmr_d   = TMR_W'(OPEN_CYCLES);
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            // The wrong digit is not retried as digit 0.
            idx_d = '0;
            if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
              state_d = ST_LOCKOUT;
              fail_d  = FAIL_W'(MAX_FAIL);
              tmr_d   = TMR_W'(LOCKOUT_CYCLES);
            end else begin
              fail_d = fail_q + FAIL_W'(1);
            end
          end
        end
      end
      ST_OPEN: begin
        if (code_load) code_d = code_in;
        if (OPEN_CYCLES != 0) begin
          // The timer holds the number of open cycles still to come,
          // so the edge that sees 1 is the last one spent open.
          if (tmr_q <= TMR_W'(1)) begin
            state_d = ST_ENTRY;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        if (new_digit) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_q <= TMR_W'(1)) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
          idx_d   = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_ENTRY;
        idx_d   = '0;
        fail_d  = '0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ENTRY;
      code_q  <= DEFAULT_CODE;
      idx_q   <= '0;
      fail_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
    end
  end

  // Outputs decode registered state only.
  assign opened     = (state_q == ST_OPEN);
  assign locked_out = (state_q == ST_LOCKOUT);
  assign progress   = idx_q;
  assign fail_count = fail_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/code_lock.md
# code_lock

Parametrised sequential combination lock; successor to the fixed 3-digit, 4-bit lock in the lock hardware block. Accepts one digit per `new` strobe and compares it against a programmable code of `CODE_LEN` digits. Adds a failed-attempt lockout, an automatic relock timeout, and in-place code reprogramming while open. Sits between the keypad/digit source and the door-actuator logic.

## Interface

- `DIGIT_W`, default 4: width of one digit.
- `CODE_LEN`, default 3: digits per code; must be ≥1.
- `DEFAULT_CODE`, default {4'd3,4'd2,4'd1}: reset code, `CODE_LEN*DIGIT_W` bits. Digit 0 (first entered) is in the LSBs.
- `MAX_FAIL`, default 3: wrong digits before lockout; must be ≥1.
- `LOCKOUT_CYCLES`, default 16: lockout duration in clocks; must be ≥1.
- `OPEN_CYCLES`, default 8: open duration in clocks; 0 disables the timeout.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `value`  in  `DIGIT_W`  digit, sampled only when `new`=1.
- `new`  in  1  one-cycle strobe: one digit per high cycle.
- `code_in`  in  `CODE_LEN*DIGIT_W`  replacement code; same digit order as `DEFAULT_CODE`.
- `code_load`  in  1  load `code_in`; honoured only in OPEN.
- `opened`  out  1  high in OPEN.
- `locked_out`  out  1  high in LOCKOUT.
- `progress`  out  `$clog2(CODE_LEN+1)`  correct digits entered so far.
- `fail_count`  out  `$clog2(MAX_FAIL+1)`  wrong digits since last success or lockout.

## Operation

- **States:** ENTRY, OPEN, LOCKOUT.
- **Registers:** `code_reg`, digit index `idx` (drives `progress`), fail counter, one shared down-timer.
- **Reset:** state ENTRY, `code_reg`=`DEFAULT_CODE`, `idx`=0, fail=0, timer=0.
  - Outputs after reset: `opened`=0, `locked_out`=0, `progress`=0, `fail_count`=0.
- **ENTRY, `new`=1:** compare `value` with digit `idx` of `code_reg`.
  - Match with `idx`<`CODE_LEN`-1: `idx`++.
  - Match with `idx`=`CODE_LEN`-1: go to OPEN, `idx`=0, fail=0, timer=`OPEN_CYCLES`.
  - Mismatch: `idx`=0 and fail++. The mismatching digit is not re-evaluated as digit 0.
  - Mismatch that makes fail reach `MAX_FAIL`: go to LOCKOUT, timer=`LOCKOUT_CYCLES`.
- **ENTRY, `new`=0:** hold all state.
- **OPEN:**
  - `new`=1 (any value): consumed, relock to ENTRY; `idx`=0.
  - Timeout enabled (`OPEN_CYCLES`>0): timer decrements each cycle; the cycle it reaches 0 relocks to ENTRY.
  - `code_load`=1: `code_reg`←`code_in`. Stays OPEN; timer is not reloaded.
  - `new` and `code_load` in the same cycle: both take effect (load, then relock).
- **LOCKOUT:** `new` and `code_load` ignored; timer decrements. When it expires: ENTRY, fail=0, `idx`=0.
- **`code_load` outside OPEN:** ignored.
- **Outputs:** all registered, decoded from state and counters. No combinational path from inputs to outputs.
- **Digit comparison:** exact `DIGIT_W`-bit equality; any X/Z in `value` counts as a mismatch.

## Timing

- **Open latency:** the edge that samples the final correct digit sets `opened`; it is high from the next cycle.
- **Open duration:** with no `new`, `opened` is high for exactly `OPEN_CYCLES` cycles. With `OPEN_CYCLES`=0 it stays high until a `new` strobe.
- **Relock by strobe:** `new` in OPEN at edge N gives `opened`=0 after edge N; that digit does not count toward entry.
- **Lockout duration:** `locked_out` is high for exactly `LOCKOUT_CYCLES` cycles. A `new` on the first cycle after lockout ends is evaluated normally.
- **Code load:** a `code_load` accepted at edge N makes the new code effective for digits sampled at edge N+1 onward.
- **Reset mid-operation:** reset at any edge, in any state, returns everything to reset values at that edge. This includes `code_reg` reverting to `DEFAULT_CODE`.
- **Throughput:** back-to-back `new` strobes (every cycle) are supported.

## Test plan

- Defaults; strobes 1,2,3 on consecutive cycles → `progress` 1,2 then `opened`=1 the cycle after the third strobe; `opened`=1 for 8 cycles, then 0.
- Strobes 1,5 then 1,2,3 → after 5: `progress`=0, `fail_count`=1. After 3: `opened`=1 and `fail_count`=0.
- Three wrong digits (7,7,7) → `locked_out`=1 for 16 cycles. Strobes 1,2,3 during lockout leave `opened`=0. After lockout, 1,2,3 opens the lock.
- Open; `code_load` with `code_in`={4'd9,4'd8,4'd7}; strobe `new` to relock → 1,2,3 fails and 7,8,9 opens.
- Strobes 1,2; reset on the next cycle; then strobe 3 → `progress`=0, `fail_count`=1, `opened`=0.
- `OPEN_CYCLES`=0, `CODE_LEN`=5, `DIGIT_W`=8 → the correct 5-digit code opens and `opened` stays high for 100 cycles. One `new` clears it next cycle.
